// File: rtl/framebuffer_swap_ctrl.sv
// framebuffer_swap_ctrl
//
// Double-buffer controller sitting between the graphics pipeline (writer)
// and the VGA scan-out (reader). Two single-port frame RAMs are owned by
// this block. The writer always lands in the back buffer, and the reader
// always pulls from the front buffer. A frame-complete pulse from the writer
// and a frame-start (vblank) pulse from the reader are sequenced so that
// the front/back roles swap without tearing.
//
// Ports
//   clock, reset            single clock, synchronous active-high reset
//   wr_en/wr_addr/wr_data   pixel write strobe, address and BGR555 color
//   wr_frame_done           one-cycle pulse: writer finished a frame
//   wr_ready                writes accepted (low while a swap is pending/executing)
//   rd_en/rd_addr           pixel read strobe and address
//   rd_frame_start          one-cycle pulse: reader at frame boundary
//   rd_data/rd_valid        registered read data and its strobe (2-cycle latency)
//   front_sel               buffer currently being scanned out (0 = buffer0)
//   drop_count              saturating count of writes refused while wr_ready=0
//   bufferN_*               RAM address / write data / we / ce / read data

module framebuffer_swap_ctrl #(
  parameter int ADDR_W = 17,
  parameter int DATA_W = 15,
  parameter int DEPTH  = 38400
) (
  input  logic              clock,
  input  logic              reset,

  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_frame_done,
  output logic              wr_ready,

  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_frame_start,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,

  output logic              front_sel,
  output logic [7:0]        drop_count,

  output logic [ADDR_W-1:0] buffer0_address,
  output logic [DATA_W-1:0] buffer0_din,
  output logic              buffer0_we,
  output logic              buffer0_ce,
  input  logic [DATA_W-1:0] buffer0_dout,

  output logic [ADDR_W-1:0] buffer1_address,
  output logic [DATA_W-1:0] buffer1_din,
  output logic              buffer1_we,
  output logic              buffer1_ce,
  input  logic [DATA_W-1:0] buffer1_dout
);

  // Swap sequencing states
  localparam logic [1:0] ST_RUN  = 2'd0;
  localparam logic [1:0] ST_PEND = 2'd1;
  localparam logic [1:0] ST_SWAP = 2'd2;

  // Depth expressed at address width so range compares stay width-matched
  localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);

  logic [1:0] state;
  logic [1:0] state_next;

  logic wr_in_range;
  logic rd_in_range;
  logic back_we;

  // Read pipeline stage 1: which buffer the read was aimed at, and whether
  // the address was legal. Stage 2 is rd_data/rd_valid themselves.
  logic rd_pend_q;
  logic rd_sel_q;
  logic rd_in_range_q;
  logic [DATA_W-1:0] rd_dout_sel;

  assign wr_in_range = (wr_addr < DEPTH_A);
  assign rd_in_range = (rd_addr < DEPTH_A);

  // wr_ready depends only on the registered state, so no combinational
  // path exists from the reader's pulses to the writer's handshake.
  assign wr_ready = (state == ST_RUN);

  assign back_we = wr_en & wr_ready & wr_in_range;

  // Next-state logic. Once a frame is complete the writer is held off until
  // the reader reaches vblank; extra frame-done pulses while waiting are
  // ignored. A lone frame-start in RUN means the reader simply rescans the
  // same front buffer.
  always_comb begin
    state_next = state;
    case (state)
      ST_RUN: begin
        if (wr_frame_done) begin
          state_next = rd_frame_start ? ST_SWAP : ST_PEND;
        end
      end
      ST_PEND: begin
        if (rd_frame_start) begin
          state_next = ST_SWAP;
        end
      end
      ST_SWAP: begin
        state_next = ST_RUN;
      end
      default: begin
        state_next = ST_RUN;
      end
    endcase
  end

  // State register and front-buffer selector. The selector flips at the
  // end of the single SWAP cycle; a reset discards any swap in progress.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= ST_RUN;
      front_sel <= 1'b0;
    end else begin
      state <= state_next;
      if (state == ST_SWAP) begin
        front_sel <= ~front_sel;
      end
    end
  end

  // RAM port steering. The front buffer only ever sees reads, the back
  // buffer only ever sees writes. The back buffer's ce follows wr_en even
  // when the write is suppressed; only we is qualified.
  always_comb begin
    buffer0_address = '0;
    buffer0_din     = '0;
    buffer0_we      = 1'b0;
    buffer0_ce      = 1'b0;
    buffer1_address = '0;
    buffer1_din     = '0;
    buffer1_we      = 1'b0;
    buffer1_ce      = 1'b0;
    if (!front_sel) begin
      buffer0_address = rd_addr;
      buffer0_ce      = rd_en;
      buffer1_address = wr_addr;
      buffer1_din     = wr_data;
      buffer1_ce      = wr_en;
      buffer1_we      = back_we;
    end else begin
      buffer1_address = rd_addr;
      buffer1_ce      = rd_en;
      buffer0_address = wr_addr;
      buffer0_din     = wr_data;
      buffer0_ce      = wr_en;
      buffer0_we      = back_we;
    end
  end

  // Writes refused because a swap is pending or executing are counted so
  // the graphics side can detect it overran the frame boundary. Addresses
  // out of range in RUN are silently dropped and not counted here.
  always_ff @(posedge clock) begin
    if (reset) begin
      drop_count <= 8'd0;
    end else if (wr_en && !wr_ready && (drop_count != 8'hFF)) begin
      drop_count <= drop_count + 8'd1;
    end
  end

  // Read stage 1: capture the buffer index at issue time. The RAM output
  // arrives a cycle later, by which point front_sel may already have
  // flipped, so the dout mux must use this registered copy.
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_pend_q     <= 1'b0;
      rd_sel_q      <= 1'b0;
      rd_in_range_q <= 1'b0;
    end else begin
      rd_pend_q     <= rd_en;
      rd_sel_q      <= front_sel;
      rd_in_range_q <= rd_in_range;
    end
  end

  assign rd_dout_sel = rd_sel_q ? buffer1_dout : buffer0_dout;

  // Read stage 2: register the selected RAM word. Illegal addresses still
  // produce a valid strobe so the scan-out timing never stalls, but the
  // data is forced to black.
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= rd_pend_q;
      if (rd_pend_q) begin
        rd_data <= rd_in_range_q ? rd_dout_sel : '0;
      end
    end
  end

endmodule

// File: tb/tb_framebuffer_swap_ctrl.sv
// tb_framebuffer_swap_ctrl
//
// Directed bench for framebuffer_swap_ctrl. Two behavioural single-port
// RAMs (read data one cycle after address) stand in for the frame buffers,
// with a backdoor preload port so test content can be placed in either
// buffer regardless of which one is currently front.

module tb_framebuffer_swap_ctrl;

  localparam int ADDR_W = 17;
  localparam int DATA_W = 15;
  localparam int DEPTH  = 38400;

  logic              clock = 1'b0;
  logic              reset;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_frame_done;
  logic              wr_ready;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_frame_start;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              front_sel;
  logic [7:0]        drop_count;
  logic [ADDR_W-1:0] buffer0_address, buffer1_address;
  logic [DATA_W-1:0] buffer0_din, buffer1_din;
  logic              buffer0_we, buffer1_we;
  logic              buffer0_ce, buffer1_ce;
  logic [DATA_W-1:0] buffer0_dout, buffer1_dout;

  bit   [DATA_W-1:0] mem0 [0:DEPTH-1];
  bit   [DATA_W-1:0] mem1 [0:DEPTH-1];

  logic              preloadEn   = 1'b0;
  logic              preloadBuf  = 1'b0;
  logic [ADDR_W-1:0] preloadAddr = '0;
  logic [DATA_W-1:0] preloadData = '0;

  int checkCount = 0;
  int errorCount = 0;

  framebuffer_swap_ctrl #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .DEPTH (DEPTH)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .wr_en          (wr_en),
    .wr_addr        (wr_addr),
    .wr_data        (wr_data),
    .wr_frame_done  (wr_frame_done),
    .wr_ready       (wr_ready),
    .rd_en          (rd_en),
    .rd_addr        (rd_addr),
    .rd_frame_start (rd_frame_start),
    .rd_data        (rd_data),
    .rd_valid       (rd_valid),
    .front_sel      (front_sel),
    .drop_count     (drop_count),
    .buffer0_address(buffer0_address),
    .buffer0_din    (buffer0_din),
    .buffer0_we     (buffer0_we),
    .buffer0_ce     (buffer0_ce),
    .buffer0_dout   (buffer0_dout),
    .buffer1_address(buffer1_address),
    .buffer1_din    (buffer1_din),
    .buffer1_we     (buffer1_we),
    .buffer1_ce     (buffer1_ce),
    .buffer1_dout   (buffer1_dout)
  );

  always #5 clock = ~clock;

  // Behavioural RAMs; an out-of-range address reads back non-zero garbage
  // so that masking of illegal reads is observable.
  always @(posedge clock) begin
    if (preloadEn) begin
      if (preloadBuf) mem1[int'(preloadAddr)] <= preloadData;
      else            mem0[int'(preloadAddr)] <= preloadData;
    end
    if (buffer0_ce) begin
      if (buffer0_we && (int'(buffer0_address) < DEPTH)) mem0[int'(buffer0_address)] <= buffer0_din;
      buffer0_dout <= (int'(buffer0_address) < DEPTH) ? mem0[int'(buffer0_address)] : 15'h7FFF;
    end
    if (buffer1_ce) begin
      if (buffer1_we && (int'(buffer1_address) < DEPTH)) mem1[int'(buffer1_address)] <= buffer1_din;
      buffer1_dout <= (int'(buffer1_address) < DEPTH) ? mem1[int'(buffer1_address)] : 15'h7FFF;
    end
  end

  // Advance one clock and settle just after the rising edge
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Drive every DUT input for the coming clock edge
  task automatic applyStimulus(input logic we, input logic [ADDR_W-1:0] wa,
                               input logic [DATA_W-1:0] wd, input logic wfd,
                               input logic re, input logic [ADDR_W-1:0] ra,
                               input logic rfs);
    wr_en          = we;
    wr_addr        = wa;
    wr_data        = wd;
    wr_frame_done  = wfd;
    rd_en          = re;
    rd_addr        = ra;
    rd_frame_start = rfs;
  endtask

  task automatic idle();
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b0);
  endtask

  // Backdoor write into one of the model RAMs
  task automatic preload(input logic bufSel, input logic [ADDR_W-1:0] a,
                         input logic [DATA_W-1:0] d);
    preloadEn   = 1'b1;
    preloadBuf  = bufSel;
    preloadAddr = a;
    preloadData = d;
    tick();
    preloadEn = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: actual 0x%0h required 0x%0h", tag, actual, expected);
    end
  endtask

  // Safety net in case the stimulus ever stalls
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: actual timeout required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lowCnt;
    int flipAt;
    int bad;
    logic anyWe;

    idle();
    reset = 1'b1;
    preload(1'b0, 17'd5, 15'h0A5A);

    // ---------------- reset ----------------
    repeat (3) tick();
    reset = 1'b0;
    checkOutput("rst_front_sel", 32'(front_sel), 32'd0);
    checkOutput("rst_wr_ready", 32'(wr_ready), 32'd1);
    checkOutput("rst_rd_valid", 32'(rd_valid), 32'd0);
    checkOutput("rst_drop_count", 32'(drop_count), 32'd0);

    applyStimulus(1'b1, 17'd3, 15'h1234, 1'b0, 1'b0, '0, 1'b0);
    #1;
    checkOutput("rst_b1_we", 32'(buffer1_we), 32'd1);
    checkOutput("rst_b0_we", 32'(buffer0_we), 32'd0);
    tick();
    idle();
    checkOutput("rst_mem1_3", 32'(mem1[3]), 32'h1234);

    applyStimulus(1'b0, '0, '0, 1'b0, 1'b1, 17'd5, 1'b0);
    tick();
    idle();
    checkOutput("rd_lat1_valid", 32'(rd_valid), 32'd0);
    tick();
    checkOutput("rd_lat2_valid", 32'(rd_valid), 32'd1);
    checkOutput("rd_lat2_data", 32'(rd_data), 32'h0A5A);
    tick();
    checkOutput("rd_lat3_valid", 32'(rd_valid), 32'd0);

    // ---------------- basic swap ----------------
    applyStimulus(1'b1, 17'd100, 15'h7FFF, 1'b0, 1'b0, '0, 1'b0);
    tick();
    applyStimulus(1'b0, '0, '0, 1'b1, 1'b0, '0, 1'b0);
    tick();
    idle();
    lowCnt = 0;
    flipAt = 0;
    for (int i = 1; i <= 20; i++) begin
      if (!wr_ready) lowCnt++;
      if (front_sel && flipAt == 0) flipAt = i;
      if (i == 11) applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b1);
      else idle();
      tick();
    end
    idle();
    checkOutput("swap_low_cycles", 32'(lowCnt), 32'd12);
    checkOutput("swap_flip_cycle", 32'(flipAt), 32'd13);
    checkOutput("swap_front_sel", 32'(front_sel), 32'd1);
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b1, 17'd100, 1'b0);
    tick();
    idle();
    tick();
    checkOutput("swap_rd_valid", 32'(rd_valid), 32'd1);
    checkOutput("swap_rd_data", 32'(rd_data), 32'h7FFF);

    // ---------------- simultaneous pulses ----------------
    applyStimulus(1'b0, '0, '0, 1'b1, 1'b0, '0, 1'b1);
    tick();
    idle();
    lowCnt = 0;
    flipAt = 0;
    for (int i = 1; i <= 6; i++) begin
      if (!wr_ready) lowCnt++;
      if (!front_sel && flipAt == 0) flipAt = i;
      tick();
    end
    checkOutput("simul_low_cycles", 32'(lowCnt), 32'd1);
    checkOutput("simul_flip_cycle", 32'(flipAt), 32'd2);
    checkOutput("simul_front_sel", 32'(front_sel), 32'd0);

    // ---------------- range boundary and dropped writes ----------------
    applyStimulus(1'b1, 17'd38399, 15'h0111, 1'b0, 1'b0, '0, 1'b0);
    #1;
    checkOutput("wr_last_addr_we", 32'(buffer1_we), 32'd1);
    tick();
    applyStimulus(1'b1, 17'd38400, 15'h1555, 1'b0, 1'b0, '0, 1'b0);
    #1;
    checkOutput("wr_oor_we", 32'({buffer0_we, buffer1_we}), 32'd0);
    tick();
    idle();
    checkOutput("wr_oor_drop", 32'(drop_count), 32'd0);
    checkOutput("wr_oor_ready", 32'(wr_ready), 32'd1);

    applyStimulus(1'b0, '0, '0, 1'b1, 1'b0, '0, 1'b0);
    tick();
    idle();
    checkOutput("pend_wr_ready", 32'(wr_ready), 32'd0);
    anyWe = 1'b0;
    for (int i = 0; i < 300; i++) begin
      applyStimulus(1'b1, 17'(i), 15'(i + 1), (i == 50), 1'b0, '0, 1'b0);
      #1;
      if (buffer0_we || buffer1_we) anyWe = 1'b1;
      tick();
      if (i == 0) checkOutput("drop_first", 32'(drop_count), 32'd1);
    end
    idle();
    checkOutput("drop_no_we", 32'(anyWe), 32'd0);
    checkOutput("drop_saturate", 32'(drop_count), 32'd255);
    checkOutput("drop_still_pend", 32'(wr_ready), 32'd0);

    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b1);
    tick();
    idle();
    checkOutput("pend_swap_cycle", 32'(wr_ready), 32'd0);
    tick();
    checkOutput("pend_done_front", 32'(front_sel), 32'd1);
    checkOutput("pend_done_ready", 32'(wr_ready), 32'd1);
    applyStimulus(1'b0, '0, '0, 1'b1, 1'b0, '0, 1'b1);
    tick();
    idle();
    tick();
    checkOutput("back_to_buf0", 32'(front_sel), 32'd0);

    // ---------------- read stream across swap ----------------
    preload(1'b0, 17'd7, 15'h001F);
    preload(1'b1, 17'd7, 15'h03E0);
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b1, 17'd7, 1'b0);
    repeat (3) tick();
    applyStimulus(1'b0, '0, '0, 1'b1, 1'b1, 17'd7, 1'b1);
    tick();
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b1, 17'd7, 1'b0);
    flipAt = 0;
    for (int i = 1; i <= 10; i++) begin
      checkOutput($sformatf("stream_valid_%0d", i), 32'(rd_valid), 32'd1);
      checkOutput($sformatf("stream_data_%0d", i), 32'(rd_data),
                  (i >= 4) ? 32'h03E0 : 32'h001F);
      if (front_sel && flipAt == 0) flipAt = i;
      tick();
    end
    checkOutput("stream_flip_cycle", 32'(flipAt), 32'd2);
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b1, 17'd40000, 1'b0);
    tick();
    idle();
    tick();
    checkOutput("rd_oor_valid", 32'(rd_valid), 32'd1);
    checkOutput("rd_oor_data", 32'(rd_data), 32'd0);
    tick();
    checkOutput("rd_oor_after", 32'(rd_valid), 32'd0);

    // ---------------- reset during PEND ----------------
    applyStimulus(1'b0, '0, '0, 1'b1, 1'b0, '0, 1'b0);
    tick();
    idle();
    checkOutput("rstpend_in_pend", 32'(wr_ready), 32'd0);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkOutput("rstpend_ready", 32'(wr_ready), 32'd1);
    checkOutput("rstpend_front", 32'(front_sel), 32'd0);
    checkOutput("rstpend_drop", 32'(drop_count), 32'd0);
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b1);
    tick();
    idle();
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (front_sel || !wr_ready) bad++;
      tick();
    end
    checkOutput("rstpend_no_swap", 32'(bad), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
